tag_tracker: RTL and testbench
==============================

# tag_tracker

- Sits directly downstream of `tag_queue`.
- Pulls a free tag from `tag_queue` for each issued instruction and stores that instruction's metadata (e.g. destination register) in a per-tag table.
- On completion, looks up the metadata by tag, returns it to writeback, and returns the tag to `tag_queue` on its `free_i`/`tag_i` ports.
- Also tracks inflight count and flags illegal completions.

## Interface
- `NumTags`, 16: tags per warp; must match the `tag_queue` instance; TagWidth = $clog2(NumTags).
- `NumCmpl`, 2: completion ports; equals `tag_queue` `NumTagIn`.
- `DataWidth`, 8: metadata bits stored per tag.
- `clk_i` in 1: clock; one clock domain.
- `rst_i` in 1: reset, asynchronous, active-high.
- `tq_valid_i` in 1: `tag_queue` has a free tag.
- `tq_tag_i` in TagWidth: free tag offered by `tag_queue`.
- `tq_get_o` out 1: consume the offered tag.
- `alloc_valid_i` in 1: issue request.
- `alloc_data_i` in DataWidth: metadata for the new tag.
- `alloc_ready_o` out 1: request accepted this cycle.
- `alloc_tag_o` out TagWidth: tag assigned to the accepted request.
- `cmpl_valid_i` in NumCmpl: completion strobes.
- `cmpl_tag_i` in NumCmpl×TagWidth: completing tags.
- `rsp_valid_o` out NumCmpl: metadata lookup result valid.
- `rsp_tag_o` out NumCmpl×TagWidth: tag of the result.
- `rsp_data_o` out NumCmpl×DataWidth: stored metadata.
- `free_o` out NumCmpl: to `tag_queue` `free_i`.
- `free_tag_o` out NumCmpl×TagWidth: to `tag_queue` `tag_i`.
- `inflight_o` out $clog2(NumTags+1): number of tags currently allocated.
- `idle_o` out 1: `inflight_o == 0`.
- `err_o` out 1: sticky illegal-completion flag.

## Operation
**Per-tag state**
- Each tag has a `busy` bit and a `data` register.

**Allocation** (combinational handshake)
- `alloc_ready_o = tq_valid_i`.
- `tq_get_o = alloc_valid_i & tq_valid_i`.
- `alloc_tag_o = tq_tag_i`.
- On accept, at the clock edge: `busy[tag]` is set and `data[tag]` = `alloc_data_i`.

**Completion**
- A completion on port i is legal iff `busy[cmpl_tag_i[i]]` is set and no lower-indexed port completes the same tag in the same cycle.
- For a legal completion:
  - `busy` is cleared at the edge.
  - `rsp_*[i]` and `free_*[i]` are registered and asserted for exactly one cycle after the edge.
- An illegal completion produces no response and no free. With `TAG_TRACKER_ERR_EN` it also sets `err_o`.

**Inflight counter**
- Next value = `inflight_o` + accepted alloc − legal completions.
- Never wraps. Underflow is impossible because only legal completions decrement it.

**Boundary cases**
- Full (`inflight_o == NumTags`): `tag_queue` is empty, so `tq_valid_i` = 0 and `alloc_ready_o` = 0.
- Allocation and completion of different tags in the same cycle: both take effect; the counter changes by +1−k.
- Same-tag allocation and completion in the same cycle cannot occur: a tag returns to `tag_queue` only one cycle after its `busy` bit clears.
- Reset mid-operation: all `busy` bits are cleared, inflight tags are lost, and `tag_queue` must be reset together with this block.

## Timing
- Reset values:
  - `tq_get_o`, `alloc_ready_o`: combinational, driven by `tq_valid_i` / `alloc_valid_i`.
  - `rsp_valid_o`, `free_o`: 0.
  - `rsp_tag_o`, `rsp_data_o`, `free_tag_o`: 0.
  - `inflight_o`: 0.
  - `idle_o`: 1.
  - `err_o`: 0.
  - All `busy` bits: 0.
- Allocation: zero-cycle handshake; the tag is marked busy from cycle t+1.
- Completion presented in cycle t → `rsp_*` and `free_*` valid in cycle t+1, one cycle wide. Responses have no back-pressure.
- Tag reuse: a freed tag reaches `tag_queue` at t+1 and can be reallocated at the earliest in t+2.
- `inflight_o` and `idle_o` are registered and reflect events up to the previous edge.

## Configuration
- `TAG_TRACKER_ERR_EN` defined:
  - Illegal completions are detected as above.
  - `err_o` sets and stays set until reset.
- `TAG_TRACKER_ERR_EN` undefined:
  - `err_o` is tied to 0.
  - Every completion is treated as legal: it frees its tag and responds, the `busy` bit is cleared regardless of its state, and stale `data` is returned for non-busy tags.
  - The decrement saturates at 0.

## Test plan
- After reset, `tq_valid_i`=1, `tq_tag_i`=5, `alloc_valid_i`=1, `alloc_data_i`=0x3A → `tq_get_o`=1 and `alloc_tag_o`=5 in the same cycle; `inflight_o`=1 next cycle.
- Complete tag 5 on port 0 at cycle t → at t+1: `rsp_valid_o[0]`=1, `rsp_data_o[0]`=0x3A, `free_o[0]`=1, `free_tag_o[0]`=5; `inflight_o`=0, `idle_o`=1.
- Allocate 16 tags back-to-back through a real `tag_queue` → `inflight_o`=16, `alloc_ready_o`=0; one completion → allocation resumes 2 cycles later.
- Both ports complete tag 3 (busy) in the same cycle → only port 0 responds; with `TAG_TRACKER_ERR_EN`, `err_o`=1.
- Complete non-busy tag 9 with `TAG_TRACKER_ERR_EN` → no `rsp`/`free`, `err_o`=1, `inflight_o` unchanged.
- Random closed loop with `tag_queue`: 1000 frees, random completion order → every response's data matches its allocation, no duplicate tag is ever outstanding, final `inflight_o` equals outstanding allocations.

Source files
------------

// File: rtl/tag_tracker.sv
// tag_tracker: per-tag metadata table sitting downstream of tag_queue.
// Allocation takes the free tag offered by tag_queue with a zero-cycle
// handshake. Completions look up the metadata, respond one cycle later, and
// hand the tag back to tag_queue. The block also tracks the inflight count.
// Optional feature macro: TAG_TRACKER_ERR_EN (illegal-completion detection
// plus a sticky err_o). Without it every completion is accepted as legal.
module tag_tracker #(
  parameter int NumTags   = 16,
  parameter int NumCmpl   = 2,
  parameter int DataWidth = 8,
  localparam int TagWidth = $clog2(NumTags),
  localparam int CntWidth = $clog2(NumTags + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          tq_valid_i,
  input  logic [TagWidth-1:0]           tq_tag_i,
  output logic                          tq_get_o,
  input  logic                          alloc_valid_i,
  input  logic [DataWidth-1:0]          alloc_data_i,
  output logic                          alloc_ready_o,
  output logic [TagWidth-1:0]           alloc_tag_o,
  input  logic [NumCmpl-1:0]            cmpl_valid_i,
  input  logic [NumCmpl*TagWidth-1:0]   cmpl_tag_i,
  output logic [NumCmpl-1:0]            rsp_valid_o,
  output logic [NumCmpl*TagWidth-1:0]   rsp_tag_o,
  output logic [NumCmpl*DataWidth-1:0]  rsp_data_o,
  output logic [NumCmpl-1:0]            free_o,
  output logic [NumCmpl*TagWidth-1:0]   free_tag_o,
  output logic [CntWidth-1:0]           inflight_o,
  output logic                          idle_o,
  output logic                          err_o
);

  logic [NumTags-1:0]                  busy_q, busy_d;
  logic [DataWidth-1:0]                data_q [NumTags];
  logic [NumCmpl-1:0][TagWidth-1:0]    ctag;
  logic [NumCmpl-1:0]                  legal;
  logic [NumCmpl-1:0]                  rsp_valid_q;
  logic [NumCmpl-1:0][TagWidth-1:0]    rsp_tag_q;
  logic [NumCmpl-1:0][DataWidth-1:0]   rsp_data_q;
  logic [CntWidth-1:0]                 ncmpl;
  logic [CntWidth:0]                   sum;
  logic [CntWidth-1:0]                 inflight_q, inflight_d;
  logic                                idle_q;
  logic                                accept;

  assign alloc_ready_o = tq_valid_i;
  assign accept        = alloc_valid_i & tq_valid_i;
  assign tq_get_o      = accept;
  assign alloc_tag_o   = tq_tag_i;

  for (genvar i = 0; i < NumCmpl; i++) begin : g_ctag
    assign ctag[i] = cmpl_tag_i[i*TagWidth +: TagWidth];
  end

`ifdef TAG_TRACKER_ERR_EN
  logic [NumCmpl-1:0] dup;
  logic [NumCmpl-1:0] illegal;
  logic               err_q;

  // A port loses to any lower-indexed port completing the same tag.
  always_comb begin
    dup = '0;
    for (int i = 1; i < NumCmpl; i++)
      for (int j = 0; j < i; j++)
        if (cmpl_valid_i[j] && ctag[j] == ctag[i]) dup[i] = 1'b1;
  end

  // Legal only when the tag is outstanding and not already claimed this cycle.
  always_comb begin
    legal = '0;
    for (int i = 0; i < NumCmpl; i++)
      legal[i] = cmpl_valid_i[i] & busy_q[ctag[i]] & ~dup[i];
  end

  assign illegal = cmpl_valid_i & ~legal;

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= err_q | (|illegal);
  end

  assign err_o = err_q;
`else
  assign legal = cmpl_valid_i;
  assign err_o = 1'b0;
`endif

  // Busy vector: clear completed tags, then mark the newly allocated one.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NumCmpl; i++)
      if (legal[i]) busy_d[ctag[i]] = 1'b0;
    if (accept) busy_d[tq_tag_i] = 1'b1;
  end

  // Inflight next value: +1 per accepted alloc, -1 per legal completion.
  always_comb begin
    ncmpl = '0;
    for (int i = 0; i < NumCmpl; i++)
      ncmpl = ncmpl + CntWidth'(legal[i]);
    sum = {1'b0, inflight_q} + (CntWidth+1)'(accept);
`ifdef TAG_TRACKER_ERR_EN
    inflight_d = CntWidth'(sum - {1'b0, ncmpl});
`else
    // Completions of non-busy tags are accepted here, so clamp at zero.
    inflight_d = (sum > {1'b0, ncmpl}) ? CntWidth'(sum - {1'b0, ncmpl}) : '0;
`endif
  end

  // Busy bits and counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q     <= '0;
      inflight_q <= '0;
      idle_q     <= 1'b1;
    end else begin
      busy_q     <= busy_d;
      inflight_q <= inflight_d;
      idle_q     <= (inflight_d == '0);
    end
  end

  // Metadata table, written on accepted allocation.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NumTags; k++) data_q[k] <= '0;
    end else if (accept) begin
      data_q[tq_tag_i] <= alloc_data_i;
    end
  end

  // One-cycle response/free pulse; tag and data hold until the next legal one.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid_q <= '0;
      rsp_tag_q   <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= legal;
      for (int i = 0; i < NumCmpl; i++) begin
        if (legal[i]) begin
          rsp_tag_q[i]  <= ctag[i];
          rsp_data_q[i] <= data_q[ctag[i]];
        end
      end
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_tag_o   = rsp_tag_q;
  assign rsp_data_o  = rsp_data_q;
  assign free_o      = rsp_valid_q;
  assign free_tag_o  = rsp_tag_q;
  assign inflight_o  = inflight_q;
  assign idle_o      = idle_q;

endmodule

// File: tb/tb_tag_tracker.sv
// Directed + closed-loop bench for tag_tracker with a behavioural tag_queue
// and a scoreboard of expected responses.
module tb_tag_tracker;

`ifdef TAG_TRACKER_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_i;
  logic       tq_valid_i;
  logic [3:0] tq_tag_i;
  logic       tq_get_o;
  logic       alloc_valid_i;
  logic [7:0] alloc_data_i;
  logic       alloc_ready_o;
  logic [3:0] alloc_tag_o;
  logic [1:0] cmpl_valid_i;
  logic [7:0] cmpl_tag_i;
  logic [1:0] rsp_valid_o;
  logic [7:0] rsp_tag_o;
  logic [15:0] rsp_data_o;
  logic [1:0] free_o;
  logic [7:0] free_tag_o;
  logic [4:0] inflight_o;
  logic       idle_o;
  logic       err_o;

  tag_tracker dut (
    .clk_i(clk), .rst_i(rst_i),
    .tq_valid_i(tq_valid_i), .tq_tag_i(tq_tag_i), .tq_get_o(tq_get_o),
    .alloc_valid_i(alloc_valid_i), .alloc_data_i(alloc_data_i),
    .alloc_ready_o(alloc_ready_o), .alloc_tag_o(alloc_tag_o),
    .cmpl_valid_i(cmpl_valid_i), .cmpl_tag_i(cmpl_tag_i),
    .rsp_valid_o(rsp_valid_o), .rsp_tag_o(rsp_tag_o), .rsp_data_o(rsp_data_o),
    .free_o(free_o), .free_tag_o(free_tag_o),
    .inflight_o(inflight_o), .idle_o(idle_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         port;
    logic [3:0] tag;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  int         fq[$];
  bit         use_tq;
  logic [15:0] busy_m;
  logic [7:0] data_m [16];
  int         cnt_m;
  logic       err_m;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    busy_m = '0;
    cnt_m  = 0;
    err_m  = 1'b0;
    for (int k = 0; k < 16; k++) data_m[k] = '0;
    exp_q.delete();
    fq.delete();
    for (int k = 0; k < 16; k++) fq.push_back(k);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1; tq_valid_i = 1'b1; tq_tag_i = 4'd0; alloc_valid_i = 1'b0;
    alloc_data_i = '0; cmpl_valid_i = '0; cmpl_tag_i = '0;
    model_reset();
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_rsp_valid", rsp_valid_o, 2'b00);
    chk("rst_free", free_o, 2'b00);
    chk("rst_rsp_tag", rsp_tag_o, 8'h00);
    chk("rst_rsp_data", rsp_data_o, 16'h0000);
    chk("rst_free_tag", free_tag_o, 8'h00);
    chk("rst_inflight", inflight_o, 5'd0);
    chk("rst_idle", idle_o, 1'b1);
    chk("rst_err", err_o, 1'b0);
    chk("rst_alloc_ready", alloc_ready_o, 1'b1);
    chk("rst_tq_get", tq_get_o, 1'b0);
    tq_valid_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  // One clock: check handshake, predict the edge, then check registered outputs.
  task automatic tick();
    logic       g, acc, lg, dupl;
    logic [1:0] f, exp_v;
    logic [7:0] ft;
    logic [3:0] t, etag [2];
    logic [7:0] edat [2];
    logic [15:0] bsnap;
    int         nleg;
    exp_t       e;
    #1;
    acc = alloc_valid_i & tq_valid_i;
    chk("tq_get", tq_get_o, acc);
    chk("alloc_ready", alloc_ready_o, tq_valid_i);
    chk("alloc_tag", alloc_tag_o, tq_tag_i);
    g = tq_get_o; f = free_o; ft = free_tag_o;
    bsnap = busy_m;
    nleg = 0;
    for (int i = 0; i < 2; i++) begin
      if (cmpl_valid_i[i]) begin
        t = cmpl_tag_i[i*4 +: 4];
        dupl = (i == 1) && cmpl_valid_i[0] && (cmpl_tag_i[3:0] == t);
        lg = ErrEn ? (bsnap[t] && !dupl) : 1'b1;
        if (lg) begin
          e.port = i; e.tag = t; e.data = data_m[t];
          exp_q.push_back(e);
          busy_m[t] = 1'b0;
          nleg++;
        end else begin
          err_m = 1'b1;
        end
      end
    end
    if (acc) begin
      chk("no_dup_outstanding", busy_m[tq_tag_i], 1'b0);
      busy_m[tq_tag_i] = 1'b1;
      data_m[tq_tag_i] = alloc_data_i;
    end
    cnt_m = cnt_m + int'(acc) - nleg;
    if (cnt_m < 0) cnt_m = 0;
    @(posedge clk);
    if (use_tq) begin
      if (g) void'(fq.pop_front());
      for (int i = 0; i < 2; i++)
        if (f[i]) fq.push_back(int'(ft[i*4 +: 4]));
    end
    @(negedge clk);
    exp_v = '0;
    etag[0] = '0; etag[1] = '0; edat[0] = '0; edat[1] = '0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      exp_v[e.port] = 1'b1;
      etag[e.port] = e.tag;
      edat[e.port] = e.data;
    end
    chk("rsp_valid", rsp_valid_o, exp_v);
    chk("free", free_o, exp_v);
    for (int i = 0; i < 2; i++) begin
      if (exp_v[i]) begin
        chk("rsp_tag", rsp_tag_o[i*4 +: 4], etag[i]);
        chk("rsp_data", rsp_data_o[i*8 +: 8], edat[i]);
        chk("free_tag", free_tag_o[i*4 +: 4], etag[i]);
      end
    end
    chk("inflight", inflight_o, cnt_m);
    chk("idle", idle_o, cnt_m == 0);
    chk("err", err_o, ErrEn & err_m);
    if (use_tq) begin
      tq_valid_i = (fq.size() > 0);
      tq_tag_i   = (fq.size() > 0) ? 4'(fq[0]) : 4'd0;
    end
  endtask

  initial begin
    int frees, cyc, nb, pick0, pick1;
    int blist[$];
    use_tq = 1'b0;
    do_reset();

    // Single allocation of tag 5.
    tq_valid_i = 1'b1; tq_tag_i = 4'd5; alloc_valid_i = 1'b1; alloc_data_i = 8'h3A;
    #1;
    chk("t1_tq_get", tq_get_o, 1'b1);
    chk("t1_alloc_tag", alloc_tag_o, 4'd5);
    tick();
    chk("t1_inflight", inflight_o, 5'd1);
    alloc_valid_i = 1'b0; tq_valid_i = 1'b0;

    // Completion of tag 5 on port 0.
    cmpl_valid_i = 2'b01; cmpl_tag_i = 8'h05;
    tick();
    cmpl_valid_i = 2'b00;
    chk("t2_rsp_valid0", rsp_valid_o[0], 1'b1);
    chk("t2_rsp_data0", rsp_data_o[7:0], 8'h3A);
    chk("t2_free0", free_o[0], 1'b1);
    chk("t2_free_tag0", free_tag_o[3:0], 4'd5);
    chk("t2_idle", idle_o, 1'b1);
    tick();
    chk("t2_pulse_width", rsp_valid_o, 2'b00);

    // Both ports complete busy tag 3.
    tq_valid_i = 1'b1; tq_tag_i = 4'd3; alloc_valid_i = 1'b1; alloc_data_i = 8'h55;
    tick();
    alloc_valid_i = 1'b0; tq_valid_i = 1'b0;
    cmpl_valid_i = 2'b11; cmpl_tag_i = 8'h33;
    tick();
    cmpl_valid_i = 2'b00;
    chk("t4_rsp_valid", rsp_valid_o, ErrEn ? 2'b01 : 2'b11);
    chk("t4_rsp_data0", rsp_data_o[7:0], 8'h55);
    chk("t4_err", err_o, ErrEn);

    // Completion of non-busy tag 9 while tag 2 is outstanding.
    tq_valid_i = 1'b1; tq_tag_i = 4'd2; alloc_valid_i = 1'b1; alloc_data_i = 8'hC7;
    tick();
    alloc_valid_i = 1'b0; tq_valid_i = 1'b0;
    cmpl_valid_i = 2'b01; cmpl_tag_i = 8'h09;
    tick();
    cmpl_valid_i = 2'b00;
    chk("t5_rsp_valid", rsp_valid_o, ErrEn ? 2'b00 : 2'b01);
    chk("t5_free", free_o, ErrEn ? 2'b00 : 2'b01);
    chk("t5_err", err_o, ErrEn);
    chk("t5_inflight", inflight_o, ErrEn ? 5'd1 : 5'd0);

    // Reset mid-operation (tag 2 still busy), then fill through the tag queue.
    do_reset();
    chk("mid_rst_inflight", inflight_o, 5'd0);
    use_tq = 1'b1;
    tq_valid_i = 1'b1; tq_tag_i = 4'd0;
    alloc_valid_i = 1'b1;
    for (int k = 0; k < 16; k++) begin
      alloc_data_i = 8'h80 + 8'(k);
      tick();
    end
    #1;
    chk("full_inflight", inflight_o, 5'd16);
    chk("full_alloc_ready", alloc_ready_o, 1'b0);
    cmpl_valid_i = 2'b01; cmpl_tag_i = 8'h00;
    tick();
    cmpl_valid_i = 2'b00;
    #1;
    chk("resume_t1_ready", alloc_ready_o, 1'b0);
    tick();
    #1;
    chk("resume_t2_ready", alloc_ready_o, 1'b1);
    chk("resume_t2_tag", alloc_tag_o, 4'd0);
    alloc_data_i = 8'hE1;
    tick();
    chk("refull_inflight", inflight_o, 5'd16);
    alloc_valid_i = 1'b0;

    // Random closed loop with the tag queue model.
    frees = 0; cyc = 0;
    while (frees < 1000 && cyc < 20000) begin
      alloc_valid_i = ($urandom_range(0, 3) != 0);
      alloc_data_i  = 8'($urandom);
      cmpl_valid_i  = '0;
      cmpl_tag_i    = '0;
      blist.delete();
      for (int k = 0; k < 16; k++) if (busy_m[k]) blist.push_back(k);
      nb = blist.size();
      if (nb > 0 && $urandom_range(0, 2) != 0) begin
        pick0 = $urandom_range(0, nb - 1);
        cmpl_valid_i[0] = 1'b1;
        cmpl_tag_i[3:0] = 4'(blist[pick0]);
        frees++;
        if (nb > 1 && $urandom_range(0, 1) != 0) begin
          pick1 = $urandom_range(0, nb - 2);
          if (pick1 >= pick0) pick1++;
          cmpl_valid_i[1] = 1'b1;
          cmpl_tag_i[7:4] = 4'(blist[pick1]);
          frees++;
        end
      end
      tick();
      cyc++;
    end
    chk("loop_done", frees >= 1000, 1'b1);
    alloc_valid_i = 1'b0; cmpl_valid_i = '0;
    tick(); tick();
    chk("final_inflight", inflight_o, $countones(busy_m));
    chk("final_err", err_o, ErrEn & err_m);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
